// File: rtl/dnn_pkg.sv
// Shared types for the dnn_* post-processing blocks.
//   DATA_WIDTH     : default signed score width
//   score_t        : one class score at the default width
//   argmax_state_t : argmax scanner states
package dnn_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/dnn_result_argmax_if.sv
// Bus between the inference core / pin logic and dnn_result_argmax.
//   master : drives clear, scores_valid, scores, rd_idx; receives results
//   slave  : the argmax block
// Optional macro ARGMAX_TOP2_EN adds second_idx and margin.
interface dnn_result_argmax_if #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(N_CLASSES);

    logic                         clear;
    logic                         scores_valid;
    logic signed [DATA_WIDTH-1:0] scores [N_CLASSES];
    logic                         busy;
    logic                         result_valid;
    logic [IDX_W-1:0]             result_idx;
    logic signed [DATA_WIDTH-1:0] result_score;
    logic                         overrun;
    logic [IDX_W-1:0]             rd_idx;
    logic signed [DATA_WIDTH-1:0] rd_data;
`ifdef ARGMAX_TOP2_EN
    logic [IDX_W-1:0]             second_idx;
    logic signed [DATA_WIDTH:0]   margin;

    modport master (
        output clear, scores_valid, scores, rd_idx,
        input  busy, result_valid, result_idx, result_score, overrun, rd_data,
               second_idx, margin
    );
    modport slave (
        input  clear, scores_valid, scores, rd_idx,
        output busy, result_valid, result_idx, result_score, overrun, rd_data,
               second_idx, margin
    );
`else
    modport master (
        output clear, scores_valid, scores, rd_idx,
        input  busy, result_valid, result_idx, result_score, overrun, rd_data
    );
    modport slave (
        input  clear, scores_valid, scores, rd_idx,
        output busy, result_valid, result_idx, result_score, overrun, rd_data
    );
`endif
endinterface

// File: rtl/dnn_score_bank.sv
// Shadow register bank holding one captured set of class scores.
//   clk, clr      : clock, synchronous clear (zeroes bank and read register)
//   cap_en        : load all entries from cap_data
//   rd_idx/rd_data: registered read, out-of-range index reads entry 0
//   scan_idx/scan_data_c : combinational read used by the scanner
module dnn_score_bank #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned IDX_W     = $clog2(N_CLASSES)
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         cap_en,
    input  logic signed [DATA_WIDTH-1:0] cap_data [N_CLASSES],
    input  logic [IDX_W-1:0]             rd_idx,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    input  logic [IDX_W-1:0]             scan_idx,
    output logic signed [DATA_WIDTH-1:0] scan_data_c
);

    logic signed [DATA_WIDTH-1:0] shadow [N_CLASSES];
    logic [IDX_W-1:0]             rd_sel_c;

    // Indices past the last class alias to entry 0.
    always_comb begin
        rd_sel_c = '0;
        if (32'(rd_idx) < 32'(N_CLASSES)) rd_sel_c = rd_idx;
    end

    assign scan_data_c = shadow[scan_idx];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(N_CLASSES); i++) shadow[i] <= '0;
            rd_data <= '0;
        end else begin
            if (cap_en) begin
                for (int i = 0; i < int'(N_CLASSES); i++) shadow[i] <= cap_data[i];
            end
            rd_data <= shadow[rd_sel_c];
        end
    end

endmodule

// File: rtl/dnn_result_argmax.sv
// Argmax post-processing: captures core scores on scores_valid, scans them
// one per cycle (strict signed >, ties keep lower index) and holds the
// winning index/score until the next capture or clear.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dnn_result_argmax_if.slave (capture, result, readout)
// Optional macro ARGMAX_TOP2_EN adds runner-up index and best-second margin.
module dnn_result_argmax #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    dnn_result_argmax_if.slave bus
);
    import dnn_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_CLASSES);

    argmax_state_t                state;
    logic [IDX_W-1:0]             cnt;
    logic signed [DATA_WIDTH-1:0] best_score;
    logic [IDX_W-1:0]             best_idx;
    logic                         busy_q;
    logic                         result_valid_q;
    logic [IDX_W-1:0]             result_idx_q;
    logic signed [DATA_WIDTH-1:0] result_score_q;
    logic                         overrun_q;

    logic                         clr_c;
    logic                         cap_en_c;
    logic signed [DATA_WIDTH-1:0] scan_data_c;
    logic                         take_best_c;
    logic signed [DATA_WIDTH-1:0] nxt_best_score_c;
    logic [IDX_W-1:0]             nxt_best_idx_c;

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_WIDTH-1:0] sec_score;
    logic [IDX_W-1:0]             sec_idx;
    logic                         has_sec;
    logic [IDX_W-1:0]             second_idx_q;
    logic signed [DATA_WIDTH:0]   margin_q;
    logic signed [DATA_WIDTH-1:0] nxt_sec_score_c;
    logic [IDX_W-1:0]             nxt_sec_idx_c;
    logic                         nxt_has_sec_c;
`endif

    assign clr_c    = rst | bus.clear;
    assign cap_en_c = bus.scores_valid && (state != SCAN) && !clr_c;

    dnn_score_bank #(
        .N_CLASSES  (N_CLASSES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk         (clk),
        .clr         (clr_c),
        .cap_en      (cap_en_c),
        .cap_data    (bus.scores),
        .rd_idx      (bus.rd_idx),
        .rd_data     (bus.rd_data),
        .scan_idx    (cnt),
        .scan_data_c (scan_data_c)
    );

    // Running best after folding in the element under the scan pointer.
    always_comb begin
        take_best_c      = scan_data_c > best_score;
        nxt_best_score_c = best_score;
        nxt_best_idx_c   = best_idx;
        if (take_best_c) begin
            nxt_best_score_c = scan_data_c;
            nxt_best_idx_c   = cnt;
        end
`ifdef ARGMAX_TOP2_EN
        // A displaced best becomes runner-up; otherwise the element competes
        // for runner-up only (equal values keep the earlier index).
        nxt_sec_score_c = sec_score;
        nxt_sec_idx_c   = sec_idx;
        nxt_has_sec_c   = has_sec;
        if (take_best_c) begin
            nxt_sec_score_c = best_score;
            nxt_sec_idx_c   = best_idx;
            nxt_has_sec_c   = 1'b1;
        end else if (!has_sec || (scan_data_c > sec_score)) begin
            nxt_sec_score_c = scan_data_c;
            nxt_sec_idx_c   = cnt;
            nxt_has_sec_c   = 1'b1;
        end
`endif
    end

    // Capture/scan FSM with registered results.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            state          <= IDLE;
            cnt            <= '0;
            best_score     <= '0;
            best_idx       <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_score_q <= '0;
            overrun_q      <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_score      <= '0;
            sec_idx        <= '0;
            has_sec        <= 1'b0;
            second_idx_q   <= '0;
            margin_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.scores_valid) begin
                        best_score     <= bus.scores[0];
                        best_idx       <= '0;
                        cnt            <= IDX_W'(1);
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state          <= SCAN;
`ifdef ARGMAX_TOP2_EN
                        has_sec        <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (bus.scores_valid) overrun_q <= 1'b1;
                    best_score <= nxt_best_score_c;
                    best_idx   <= nxt_best_idx_c;
                    cnt        <= cnt + IDX_W'(1);
`ifdef ARGMAX_TOP2_EN
                    sec_score  <= nxt_sec_score_c;
                    sec_idx    <= nxt_sec_idx_c;
                    has_sec    <= nxt_has_sec_c;
`endif
                    if (cnt == IDX_W'(N_CLASSES - 1)) begin
                        state          <= DONE;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_idx_q   <= nxt_best_idx_c;
                        result_score_q <= nxt_best_score_c;
`ifdef ARGMAX_TOP2_EN
                        second_idx_q   <= nxt_sec_idx_c;
                        margin_q       <= {nxt_best_score_c[DATA_WIDTH-1], nxt_best_score_c}
                                        - {nxt_sec_score_c[DATA_WIDTH-1], nxt_sec_score_c};
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_idx   = result_idx_q;
    assign bus.result_score = result_score_q;
    assign bus.overrun      = overrun_q;
`ifdef ARGMAX_TOP2_EN
    assign bus.second_idx   = second_idx_q;
    assign bus.margin       = margin_q;
`endif

endmodule

// File: tb/tb_dnn_result_argmax.sv
// Directed bench for dnn_result_argmax at N_CLASSES=10, DATA_WIDTH=8.
// Inputs change and outputs are sampled on the falling edge; "cycle n" is
// the n-th falling edge after the one where scores_valid was raised.
module tb_dnn_result_argmax;

    localparam int unsigned N  = 10;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    dnn_result_argmax_if #(.N_CLASSES(N), .DATA_WIDTH(DW)) bus ();

    dnn_result_argmax #(.N_CLASSES(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int v[10]);
        for (int i = 0; i < 10; i++) bus.scores[i] = DW'(v[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(bus.busy), 0);
        chk({tag, "_rv"},     int'(bus.result_valid), 0);
        chk({tag, "_idx"},    int'(bus.result_idx), 0);
        chk({tag, "_score"},  int'(bus.result_score), 0);
        chk({tag, "_ovr"},    int'(bus.overrun), 0);
        chk({tag, "_rddata"}, int'(bus.rd_data), 0);
    endtask

    // Pulse scores_valid, then wait (bounded) for result_valid.
    task automatic capture_and_check(input string tag, input int exp_idx, input int exp_score);
        int cyc;
        bus.scores_valid = 1'b1;
        tick();
        bus.scores_valid = 1'b0;
        cyc = 1;
        chk({tag, "_busy_c1"}, int'(bus.busy), 1);
        chk({tag, "_rv_c1"},   int'(bus.result_valid), 0);
        while (!bus.result_valid && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 9) chk({tag, "_busy_c9"}, int'(bus.busy), 1);
        end
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_idx"},     int'(bus.result_idx), exp_idx);
        chk({tag, "_score"},   int'(bus.result_score), exp_score);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
    endtask

    initial begin
        int v1[10]  = '{3, -5, 12, 7, 0, 12, -128, 1, 2, 4};
        int vmin[10] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        int vneg[10] = '{-3, -1, -2, -4, -5, -6, -7, -8, -9, -10};
        int v100[10] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        int v5[10]  = '{-7, 5, 9, -2, 9, 0, 11, -50, 11, 3};

        rst = 1'b1;
        bus.clear = 1'b0;
        bus.scores_valid = 1'b0;
        bus.rd_idx = '0;
        load(v1);
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Mixed values, tie at index 5 loses to index 2.
        capture_and_check("t1", 2, 12);

        // All minimum value, then all negative (DONE -> new capture).
        load(vmin);
        capture_and_check("t2min", 0, -128);
        load(vneg);
        capture_and_check("t2neg", 1, -1);
        chk("t2_ovr", int'(bus.overrun), 0);

        // Readout sweep of the held bank, plus out-of-range index.
        for (int i = 0; i < 10; i++) begin
            bus.rd_idx = 4'(i);
            tick();
            tick();
            chk($sformatf("rd%0d", i), int'(bus.rd_data), vneg[i]);
        end
        bus.rd_idx = 4'd15;
        tick();
        tick();
        chk("rd15", int'(bus.rd_data), vneg[0]);

        // Overrun: second pulse mid-scan is ignored, old bank kept.
        load(v1);
        bus.rd_idx = 4'd2;
        bus.scores_valid = 1'b1;
        tick();
        bus.scores_valid = 1'b0;
        load(v100);
        tick();
        chk("scan_rd_newbank", int'(bus.rd_data), 12);
        tick();
        tick();
        bus.scores_valid = 1'b1;
        tick();
        bus.scores_valid = 1'b0;
        for (int c = 5; c < 10; c++) tick();
        chk("ovr_rv",    int'(bus.result_valid), 1);
        chk("ovr_idx",   int'(bus.result_idx), 2);
        chk("ovr_score", int'(bus.result_score), 12);
        chk("ovr_flag",  int'(bus.overrun), 1);
        tick();
        chk("ovr_sticky", int'(bus.overrun), 1);
        chk("ovr_oldbank", int'(bus.rd_data), 12);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk_all_zero("clear");

        // Reset mid-scan, then a fresh capture.
        load(v1);
        bus.scores_valid = 1'b1;
        tick();
        bus.scores_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        repeat (3) tick();
        chk("midrst_stay_idle", int'(bus.result_valid), 0);
        load(v5);
        capture_and_check("t5", 6, 11);

`ifdef ARGMAX_TOP2_EN
        begin
            int vt[10] = '{10, 40, -20, 39, 0, 0, 0, 0, 0, 0};
            load(vt);
            capture_and_check("top2", 1, 40);
            chk("top2_second", int'(bus.second_idx), 3);
            chk("top2_margin", int'(bus.margin), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
